// File: rtl/fifo_rd_axis_bridge.sv
// fifo_rd_axis_bridge: drains the async-FIFO read port into an AXI-Stream master through a 2-entry skid buffer.
// Latency: 2 clk from the first rd_en to tvalid; 1 word/clk in steady state.
// Backpressure: tready low holds the head; rd_en stops once buffered plus in-flight words reach 2.
// Option: define RX_FRAME_CNT_EN to add a 16-bit frame_count output (count of tlast handshakes).
`timescale 1ns/1ps
module fifo_rd_axis_bridge #(
    parameter int FIFO_DATA_WIDTH = 9
) (
    input  logic                       clk_rd,
    input  logic                       reset_n,
    input  logic [FIFO_DATA_WIDTH-1:0] rd_data,
    input  logic                       rd_empty,
    output logic                       rd_en,
    output logic [FIFO_DATA_WIDTH-2:0] m_axis_tdata,
    output logic                       m_axis_tlast,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready
`ifdef RX_FRAME_CNT_EN
    ,
    output logic [15:0]                frame_count
`endif
);
    localparam int W = FIFO_DATA_WIDTH;

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [1:0]   count_q, count_d;
    logic         pending_q, pending_d;
    logic         pop;
    logic [1:0]   slot;

    assign m_axis_tvalid = (count_q != 2'd0);
    assign m_axis_tdata  = head_q[W-2:0];
    assign m_axis_tlast  = head_q[W-1];
    assign pop           = m_axis_tvalid & m_axis_tready;

    // The word returning from the FIFO lands behind whatever survives this cycle's pop.
    always_comb begin
        count_d   = count_q + {1'b0, pending_q} - {1'b0, pop};
        rd_en     = reset_n & ~rd_empty & (count_d < 2'd2);
        pending_d = rd_en;
        slot      = count_q - {1'b0, pop};
        head_d    = head_q;
        tail_d    = tail_q;
        if (pop && (count_q == 2'd2)) begin
            head_d = tail_q;
        end
        if (pending_q) begin
            if (slot == 2'd0) begin
                head_d = rd_data;
            end else begin
                tail_d = rd_data;
            end
        end
    end

    always_ff @(posedge clk_rd or negedge reset_n) begin
        if (!reset_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= 2'd0;
            pending_q <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

`ifdef RX_FRAME_CNT_EN
    logic [15:0] frame_count_q, frame_count_d;

    always_comb begin
        frame_count_d = frame_count_q;
        if (pop && m_axis_tlast) begin
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_rd or negedge reset_n) begin
        if (!reset_n) begin
            frame_count_q <= 16'd0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_fifo_rd_axis_bridge.sv
// Bench for fifo_rd_axis_bridge: a queue-based FIFO model feeds the DUT, a separate
// monitor compares every stream handshake against the in-order expected word queue.
`timescale 1ns/1ps
module tb_fifo_rd_axis_bridge;
    localparam int W = 9;

    logic         clk_rd = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] rd_data = '0;
    logic         rd_empty = 1'b1;
    logic         rd_en;
    logic [W-2:0] m_axis_tdata;
    logic         m_axis_tlast;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b0;
`ifdef RX_FRAME_CNT_EN
    logic [15:0]  frame_count;
`endif

    fifo_rd_axis_bridge #(.FIFO_DATA_WIDTH(W)) dut (
        .clk_rd        (clk_rd),
        .reset_n       (reset_n),
        .rd_data       (rd_data),
        .rd_empty      (rd_empty),
        .rd_en         (rd_en),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
`ifdef RX_FRAME_CNT_EN
        ,
        .frame_count   (frame_count)
`endif
    );

    always #5 clk_rd = ~clk_rd;

    logic [W-1:0] src_q[$];
    logic [W-1:0] exp_q[$];
    int           beat_cyc[$];
    int           checks = 0;
    int           fails = 0;
    int           cyc = 0;
    int           reads = 0;
    int           pops = 0;
    int           first_rd_cyc = -1;
    int           first_vld_cyc = -1;
    logic         rd_en_s, vld_s, tlast_s;
    logic [W-2:0] tdata_s;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_word = '0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic load(input logic [W-1:0] w);
        src_q.push_back(w);
        exp_q.push_back(w);
    endtask

    // One clock: drive at negedge, sample just after, model the FIFO read at posedge.
    task automatic step(input bit gap, input bit rdy);
        logic [W-1:0] word;
        bit           have;
        have = 1'b0;
        word = '0;
        @(negedge clk_rd);
        rd_empty      = gap || (src_q.size() == 0);
        m_axis_tready = rdy;
        #1;
        rd_en_s = rd_en;
        vld_s   = m_axis_tvalid;
        tdata_s = m_axis_tdata;
        tlast_s = m_axis_tlast;
        if (rd_en) begin
            chk("rd_en_while_empty", rd_empty, 0);
            if (!rd_empty) begin
                word = src_q.pop_front();
                have = 1'b1;
                reads++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
            end
        end
        @(posedge clk_rd);
        #1;
        rd_data = have ? word : W'($urandom);
        cyc++;
    endtask

    task automatic drain(input int limit, input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0) && (n < limit)) begin
            step(1'b0, 1'b1);
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic apply_reset(input string name);
        #3;
        reset_n = 1'b0;
        #1;
        chk({name, "_tvalid_async"}, m_axis_tvalid, 0);
        chk({name, "_rd_en_async"}, rd_en, 0);
        src_q.delete();
        exp_q.delete();
        reads = 0;
        pops  = 0;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        reset_n = 1'b1;
    endtask

    always @(negedge clk_rd) begin
        logic [W-1:0] got, e;
        #2;
        got = {m_axis_tlast, m_axis_tdata};
        if (reset_n) begin
            if (prev_stall) begin
                checks++;
                if (!m_axis_tvalid || (got != prev_word)) begin
                    fails++;
                    $display("FAIL head_stable: got vld=%0b word=0x%0h, expected vld=1 word=0x%0h",
                             m_axis_tvalid, got, prev_word);
                end
            end
            if (m_axis_tvalid && (first_vld_cyc < 0)) first_vld_cyc = cyc;
            if (m_axis_tvalid && m_axis_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL beat_unexpected: got 0x%0h, expected no beat", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got != e) begin
                        fails++;
                        $display("FAIL beat_data: got 0x%0h, expected 0x%0h", got, e);
                    end
                end
                pops++;
                beat_cyc.push_back(cyc);
            end
            checks++;
            if ((reads - pops > 2) || (reads < pops)) begin
                fails++;
                $display("FAIL occupancy: got %0d outstanding, expected 0..2", reads - pops);
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_word  = got;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        int n_rand, r0, lim;
`ifdef RX_FRAME_CNT_EN
        n_rand = 2000;
`else
        n_rand = 10000;
`endif
        // Reset held with data available: nothing may be read or presented.
        for (int i = 0; i < 64; i++) load({(i == 63), 8'(i)});
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1);
            chk("reset_rd_en", rd_en_s, 0);
            chk("reset_tvalid", vld_s, 0);
            chk("reset_tdata", {tlast_s, tdata_s}, 0);
        end
        chk("reset_no_reads", reads, 0);
        first_rd_cyc  = -1;
        first_vld_cyc = -1;
        beat_cyc.delete();
        reset_n = 1'b1;
        step(1'b0, 1'b1);
        chk("release_rd_en", rd_en_s, 1);

        // Full-rate stream of 64 words.
        drain(200, "stream_drain");
        chk("stream_latency", first_vld_cyc - first_rd_cyc, 2);
        chk("stream_beats", beat_cyc.size(), 64);
        r0 = 0;
        foreach (beat_cyc[i]) if (beat_cyc[i] != first_rd_cyc + 2 + i) r0++;
        chk("stream_gaps", r0, 0);

        // Backpressure mid-stream.
        for (int i = 0; i < 40; i++) load({1'b0, 8'(8'h40 + i)});
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0);
            if (i >= 1) begin
                chk("stall_rd_en", rd_en_s, 0);
                chk("stall_count", reads - pops, 2);
            end
        end
        drain(200, "stall_drain");

        // A single cycle of non-empty yields exactly one read.
        for (int i = 0; i < 3; i++) load({1'b0, 8'(8'hA0 + i)});
        r0 = reads;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
        chk("one_cycle_reads", reads - r0, 1);
        chk("one_cycle_left", exp_q.size(), 2);
        drain(50, "one_cycle_drain");

        // Random ready and empty toggling.
        for (int i = 0; i < n_rand; i++) load({($urandom_range(0, 7) == 0), 8'($urandom)});
        lim = 0;
        while ((exp_q.size() != 0) && (lim < 20 * n_rand)) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7);
            lim++;
        end
        chk("random_drain", exp_q.size(), 0);

        // Reset while the buffer is full; only new words may follow.
        for (int i = 0; i < 10; i++) load({1'b0, 8'(8'h55 + i)});
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        chk("prereset_vld", vld_s, 1);
        chk("prereset_count", reads - pops, 2);
        apply_reset("midframe");
        for (int i = 0; i < 5; i++) load({(i == 4), 8'(8'hC0 + i)});
        drain(50, "postreset_drain");

`ifdef RX_FRAME_CNT_EN
        apply_reset("frame_cnt");
        chk("frame_cnt_reset", frame_count, 0);
        for (int f = 0; f < 3; f++) begin
            load({1'b0, 8'(f)});
            load({1'b1, 8'(f + 16)});
        end
        drain(100, "frame_cnt_drain3");
        chk("frame_cnt_3", frame_count, 3);
        for (int f = 0; f < 65532; f++) load({1'b1, 8'($urandom)});
        drain(70000, "frame_cnt_drain_max");
        chk("frame_cnt_ffff", frame_count, 16'hFFFF);
        load({1'b1, 8'h77});
        drain(50, "frame_cnt_drain_wrap");
        chk("frame_cnt_wrap", frame_count, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
